// File: rtl/program_sequencer_pkg.sv
// Shared types and constants for the program sequencer: FSM states, opcodes and
// the instruction word layout {opcode[2:0], literal[7:0]}.
package prog_seq_pkg;

  localparam int INSTR_W = 11;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_F,
    DEC,
    EXE,
    DONE
  } state_t;

  localparam logic [2:0] ADD = 3'd0;
  localparam logic [2:0] SUB = 3'd1;
  localparam logic [2:0] AND = 3'd2;
  localparam logic [2:0] OR  = 3'd3;
  localparam logic [2:0] LDA = 3'd4;
  localparam logic [2:0] SHL = 3'd5;
  localparam logic [2:0] SHR = 3'd6;
  localparam logic [2:0] XOR = 3'd7;

  // OR #0 leaves the accumulator untouched, so it is safe to present while idle.
  localparam logic [INSTR_W-1:0] NOP = 11'h300;

  function automatic logic [INSTR_W-1:0] mk_instr(input logic [2:0] op, input logic [7:0] lit);
    return {op, lit};
  endfunction

endpackage

// File: rtl/program_sequencer_prog_mem.sv
// Program store: DEPTH x DATA_W register file, one synchronous write port and
// one asynchronous read port so the sequencer can register mem[pc] on the fetch edge.
module prog_mem #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 11
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/program_sequencer.sv
// Instruction source for the accumulator core: issues mem[pc] on each fetch strobe,
// captures the accumulator/flags produced by the previous instruction, and tracks run status.
module program_sequencer
  import prog_seq_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic [ADDR_W:0]    prog_len,
  input  logic               start,
  input  logic               halt,
  input  logic               fetch_i,
  input  logic [7:0]         acc_i,
  input  logic [3:0]         flags_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W:0]    pc_o,
  output logic [7:0]         result_o,
  output logic [3:0]         flags_o,
  output logic [ADDR_W:0]    exec_count,
  output logic               busy,
  output logic               done,
  output logic               sync_err
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  state_t             state_q, state_d;
  logic [ADDR_W:0]    pc_q, pc_d;
  logic [ADDR_W:0]    len_q, len_d;
  logic [ADDR_W:0]    exec_q, exec_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [7:0]         result_q, result_d;
  logic [3:0]         flags_q, flags_d;
  logic               serr_q, serr_d;
  logic [INSTR_W-1:0] mem_rdata;
  logic               mem_we;
  logic [ADDR_W:0]    len_clamped;

  // Loader writes are only honoured while no run is in flight.
  assign mem_we      = prog_we && (state_q == IDLE || state_q == DONE);
  assign len_clamped = (prog_len > DEPTH_W) ? DEPTH_W : prog_len;

  prog_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (INSTR_W)
  ) u_prog_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (prog_addr),
    .wdata_i (prog_data),
    .raddr_i (pc_q[ADDR_W-1:0]),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      len_q    <= '0;
      exec_q   <= '0;
      instr_q  <= NOP;
      result_q <= '0;
      flags_q  <= '0;
      serr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      len_q    <= len_d;
      exec_q   <= exec_d;
      instr_q  <= instr_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      serr_q   <= serr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    len_d    = len_q;
    exec_d   = exec_q;
    instr_d  = instr_q;
    result_d = result_q;
    flags_d  = flags_q;
    serr_d   = serr_q;
    case (state_q)
      IDLE, DONE: begin
        instr_d = NOP;
        if (start) begin
          state_d = WAIT_F;
          pc_d    = '0;
          exec_d  = '0;
          serr_d  = 1'b0;
          len_d   = len_clamped;
        end
      end
      WAIT_F: begin
        if (fetch_i) begin
          // The core has just finished the previous instruction: its result is on acc_i now.
          if (exec_q < pc_q) begin
            result_d = acc_i;
            flags_d  = flags_i;
            exec_d   = exec_q + 1'b1;
          end
          if (pc_q == len_q || halt) begin
            instr_d = NOP;
            state_d = DONE;
          end else begin
            instr_d = mem_rdata;
            state_d = DEC;
          end
        end
      end
      DEC, EXE: begin
        // A fetch here means the core's phase has slipped relative to ours.
        if (fetch_i) begin
          serr_d  = 1'b1;
          instr_d = NOP;
          state_d = IDLE;
        end else if (state_q == DEC) begin
          pc_d    = pc_q + 1'b1;
          state_d = EXE;
        end else begin
          state_d = WAIT_F;
        end
      end
      default: begin
        instr_d = NOP;
        state_d = IDLE;
      end
    endcase
  end

  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign result_o   = result_q;
  assign flags_o    = flags_q;
  assign exec_count = exec_q;
  assign busy       = (state_q == WAIT_F) || (state_q == DEC) || (state_q == EXE);
  assign done       = (state_q == DONE);
  assign sync_err   = serr_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: a free-running 3-phase core (D,E,F) executes whatever
// the sequencer issues; each run is predicted from the loaded program and checked.
module tb_program_sequencer;
  import prog_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [10:0] prog_data;
  logic [4:0]  prog_len;
  logic        start;
  logic        halt;
  logic        fetch_i;
  logic [7:0]  acc_i;
  logic [3:0]  flags_i;
  logic [10:0] instr_o;
  logic [4:0]  pc_o;
  logic [7:0]  result_o;
  logic [3:0]  flags_o;
  logic [4:0]  exec_count;
  logic        busy;
  logic        done;
  logic        sync_err;

  int checks = 0;
  int errors = 0;

  logic [10:0] prog_m [16];
  logic [7:0]  last_res;
  logic [3:0]  last_flg;
  logic        inj_fetch;

  logic [1:0]  ph;
  logic [10:0] core_ir;
  logic [7:0]  core_acc;
  logic [3:0]  core_flags;

  always #5 clk = ~clk;

  program_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .prog_len   (prog_len),
    .start      (start),
    .halt       (halt),
    .fetch_i    (fetch_i),
    .acc_i      (acc_i),
    .flags_i    (flags_i),
    .instr_o    (instr_o),
    .pc_o       (pc_o),
    .result_o   (result_o),
    .flags_o    (flags_o),
    .exec_count (exec_count),
    .busy       (busy),
    .done       (done),
    .sync_err   (sync_err)
  );

  // Accumulator ALU: returns {Z,C,N,V, result}.
  function automatic logic [11:0] alu(input logic [10:0] ir, input logic [7:0] a);
    logic [2:0] op;
    logic [7:0] lit;
    logic [7:0] r;
    logic [8:0] w;
    logic       c;
    logic       v;
    op  = ir[10:8];
    lit = ir[7:0];
    c   = 1'b0;
    v   = 1'b0;
    r   = 8'h00;
    case (op)
      3'd0: begin w = {1'b0, a} + {1'b0, lit}; r = w[7:0]; c = w[8];
                  v = (a[7] == lit[7]) && (r[7] != a[7]); end
      3'd1: begin w = {1'b0, a} - {1'b0, lit}; r = w[7:0]; c = w[8];
                  v = (a[7] != lit[7]) && (r[7] != a[7]); end
      3'd2: r = a & lit;
      3'd3: r = a | lit;
      3'd4: r = lit;
      3'd5: begin r = {a[6:0], 1'b0}; c = a[7]; end
      3'd6: begin r = {1'b0, a[7:1]}; c = a[0]; end
      default: r = a ^ lit;
    endcase
    return {(r == 8'h00), c, r[7], v, r};
  endfunction

  // Core: latches `in` at the end of D, updates acc at the end of E, strobes f during F.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph         <= 2'd0;
      core_ir    <= NOP;
      core_acc   <= 8'h00;
      core_flags <= 4'h0;
    end else begin
      ph <= (ph == 2'd2) ? 2'd0 : ph + 2'd1;
      if (ph == 2'd0) core_ir <= instr_o;
      if (ph == 2'd1) {core_flags, core_acc} <= alu(core_ir, core_acc);
    end
  end

  assign fetch_i = (ph == 2'd2) | inj_fetch;
  assign acc_i   = core_acc;
  assign flags_i = core_flags;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_instr"}, 32'(instr_o), 32'(NOP));
    check_eq({tag, "_pc"}, 32'(pc_o), 0);
    check_eq({tag, "_result"}, 32'(result_o), 0);
    check_eq({tag, "_flags"}, 32'(flags_o), 0);
    check_eq({tag, "_exec"}, 32'(exec_count), 0);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_done"}, 32'(done), 0);
    check_eq({tag, "_syncerr"}, 32'(sync_err), 0);
  endtask

  task automatic load(input int n, input logic [10:0] words [16]);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      prog_we   = 1'b1;
      prog_addr = 4'(i);
      prog_data = words[i];
      prog_m[i] = words[i];
    end
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  // One run: predict the sequence of accumulator values from the program, then
  // compare every capture and the final status.
  task automatic do_run(input int len, input int halt_at, input bit wr0,
                        input logic [10:0] d0, input string tag);
    int          n;
    int          hl;
    int          prev;
    bit          fin;
    logic [7:0]  a;
    logic [11:0] r;
    logic [7:0]  er [16];
    logic [3:0]  ef [16];
    repeat (2) @(negedge clk);
    if (wr0) begin
      prog_we   = 1'b1;
      prog_addr = 4'd0;
      prog_data = d0;
      prog_m[0] = d0;
    end
    n  = (len > 16) ? 16 : len;
    hl = -1;
    if (halt_at >= 0 && halt_at < n) begin
      n  = halt_at;
      hl = halt_at;
    end
    a = core_acc;
    for (int i = 0; i < n; i++) begin
      r     = alu(prog_m[i], a);
      a     = r[7:0];
      er[i] = a;
      ef[i] = r[11:8];
    end
    start    = 1'b1;
    prog_len = 5'(len);
    if (hl == 0) halt = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    prog_we = 1'b0;
    prev    = 0;
    fin     = 1'b0;
    for (int c = 0; c < 300 && !fin; c++) begin
      if (int'(exec_count) != prev) begin
        prev = int'(exec_count);
        if (prev >= 1 && prev <= n) begin
          check_eq({tag, "_cap_res"}, 32'(result_o), 32'(er[prev-1]));
          check_eq({tag, "_cap_flg"}, 32'(flags_o), 32'(ef[prev-1]));
        end else begin
          check_eq({tag, "_cap_extra"}, 32'(prev), 32'(n));
        end
      end
      if (done) fin = 1'b1;
      else begin
        if (hl > 0 && busy && int'(pc_o) == hl) halt = 1'b1;
        @(negedge clk);
      end
    end
    if (!fin) check_eq({tag, "_timeout"}, 0, 1);
    if (n > 0) begin
      last_res = er[n-1];
      last_flg = ef[n-1];
    end
    check_eq({tag, "_done"}, 32'(done), 1);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_exec"}, 32'(exec_count), 32'(n));
    check_eq({tag, "_pc"}, 32'(pc_o), 32'(n));
    check_eq({tag, "_instr"}, 32'(instr_o), 32'(NOP));
    check_eq({tag, "_result"}, 32'(result_o), 32'(last_res));
    check_eq({tag, "_flags"}, 32'(flags_o), 32'(last_flg));
    check_eq({tag, "_syncerr"}, 32'(sync_err), 0);
    $display("run %s: len=%0d halt_at=%0d exec=%0d result=%02h flags=%04b",
             tag, len, halt_at, exec_count, result_o, flags_o);
    halt = 1'b0;
  endtask

  initial begin
    logic [10:0] w [16];
    int          len;
    int          hat;
    bit          found;

    rst_n     = 1'b0;
    prog_we   = 1'b0;
    prog_addr = 4'd0;
    prog_data = 11'd0;
    prog_len  = 5'd0;
    start     = 1'b0;
    halt      = 1'b0;
    inj_fetch = 1'b0;
    last_res  = 8'h00;
    last_flg  = 4'h0;
    for (int i = 0; i < 16; i++) w[i] = NOP;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // LDA 05, ADD 03
    w[0] = mk_instr(LDA, 8'h05);
    w[1] = mk_instr(ADD, 8'h03);
    load(2, w);
    do_run(2, -1, 1'b0, 11'd0, "t1");
    check_eq("t1_value", 32'(result_o), 32'h08);

    // LDA 80, ADD 80 overflows to zero with carry and signed overflow
    w[0] = mk_instr(LDA, 8'h80);
    w[1] = mk_instr(ADD, 8'h80);
    load(2, w);
    do_run(2, -1, 1'b0, 11'd0, "t2");
    check_eq("t2_value", 32'(result_o), 32'h00);
    check_eq("t2_flags", 32'(flags_o), 32'b1101);

    do_run(0, -1, 1'b0, 11'd0, "t3_len0");

    // Halt during instruction 2 of 5
    w[0] = mk_instr(LDA, 8'h10);
    w[1] = mk_instr(ADD, 8'h01);
    w[2] = mk_instr(ADD, 8'h02);
    w[3] = mk_instr(XOR, 8'hFF);
    w[4] = mk_instr(SHL, 8'h00);
    load(5, w);
    do_run(5, 2, 1'b0, 11'd0, "t4_halt");
    check_eq("t4_value", 32'(result_o), 32'h11);
    do_run(5, 0, 1'b0, 11'd0, "t4_start_halt");

    // Write in the same cycle as start: address 0 must read the new word
    do_run(5, -1, 1'b1, mk_instr(LDA, 8'h3C), "t_wr_start");

    // Fetch strobe injected during DEC
    @(negedge clk);
    start    = 1'b1;
    prog_len = 5'd5;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      if (busy && ph == 2'd2) found = 1'b1;
      else @(negedge clk);
    end
    check_eq("t5_reach_fetch", 32'(found), 1);
    @(negedge clk);
    inj_fetch = 1'b1;
    @(negedge clk);
    inj_fetch = 1'b0;
    check_eq("t5_syncerr", 32'(sync_err), 1);
    check_eq("t5_busy", 32'(busy), 0);
    check_eq("t5_done", 32'(done), 0);
    check_eq("t5_instr", 32'(instr_o), 32'(NOP));
    check_eq("t5_exec", 32'(exec_count), 0);
    $display("sync: sync_err=%0b busy=%0b instr=%03h", sync_err, busy, instr_o);
    do_run(5, -1, 1'b0, 11'd0, "t5_rerun");

    // Loader write while busy, then reset in EXE
    w[0] = mk_instr(LDA, 8'h11);
    w[1] = mk_instr(SUB, 8'h22);
    w[2] = mk_instr(AND, 8'hF0);
    w[3] = mk_instr(SHR, 8'h00);
    load(4, w);
    @(negedge clk);
    start    = 1'b1;
    prog_len = 5'd4;
    @(negedge clk);
    start     = 1'b0;
    prog_we   = 1'b1;
    prog_addr = 4'd0;
    prog_data = mk_instr(LDA, 8'hFF);
    @(negedge clk);
    prog_we = 1'b0;
    found   = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      if (busy && ph == 2'd1 && pc_o >= 5'd1) found = 1'b1;
      else @(negedge clk);
    end
    check_eq("t6_reach_exe", 32'(found), 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    $display("reset in EXE: pc=%0d busy=%0b result=%02h", pc_o, busy, result_o);
    @(negedge clk);
    rst_n    = 1'b1;
    last_res = 8'h00;
    last_flg = 4'h0;
    do_run(4, -1, 1'b0, 11'd0, "t6_after_rst");

    // Randomized programs, lengths (including clamped) and halt points
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 16; i++) w[i] = 11'($urandom);
      load(16, w);
      len = $urandom_range(0, 20);
      hat = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 16) : -1;
      do_run(len, hat, 1'b0, 11'd0, $sformatf("rnd%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
